// File: rtl/vip_pkg.sv
// Shared definitions for the video frame controller.
// State encoding, default geometry widths and frame counter width.
package vip_pkg;
  localparam int WW_DEF = 12;
  localparam int HW_DEF = 12;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/vip_xy_counter.sv
// Raster x/y position counter for the write side.
// Produces start-of-frame, end-of-line and end-of-frame tags per write.
module vip_xy_counter #(
  parameter int WW = 12,
  parameter int HW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic [WW-1:0] width,
  input  logic [HW-1:0] height,
  output logic          sof,
  output logic          eol,
  output logic          eof
);
  logic [WW-1:0] x;
  logic [HW-1:0] y;
  logic          x_last;
  logic          y_last;

  assign x_last = x == width - WW'(1);
  assign y_last = y == height - HW'(1);
  assign sof    = step & (x == '0) & (y == '0);
  assign eol    = step & x_last;
  assign eof    = eol & y_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + HW'(1);
      end else begin
        x <= x + WW'(1);
      end
    end
  end
endmodule

// File: rtl/vip_frame_ctrl.sv
// Frame controller: gates the core's input FIFO to one frame of reads
// and tracks completion of the matching writes.
module vip_frame_ctrl
  import vip_pkg::*;
#(
  parameter int WW = WW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WW-1:0]     cfg_width,
  input  logic [HW-1:0]     cfg_height,
  input  logic              cfg_continuous,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic              src_empty,
  output logic              core_empty,
  input  logic              core_rdreq,
  input  logic              core_wrreq,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic [FCNT_W-1:0] frame_cnt
);
  localparam int TW = WW + HW;

  state_t            state;
  logic [TW-1:0]     total;
  logic [TW-1:0]     rd_cnt;
  logic [TW-1:0]     wr_cnt;
  logic [TW-1:0]     rd_nxt;
  logic [TW-1:0]     wr_nxt;
  logic [WW-1:0]     w_reg;
  logic [HW-1:0]     h_reg;
  logic [FCNT_W-1:0] fcnt;
  logic              err_q;
  logic              active;
  logic              rd_step;
  logic              wr_step;
  logic              req;
  logic              cfg_ok;
  logic              load;
  logic              bad;

  assign active  = (state == ST_RUN) || (state == ST_DRAIN);
  assign rd_step = active & core_rdreq;
  assign wr_step = active & core_wrreq;
  assign rd_nxt  = rd_cnt + TW'(rd_step);
  assign wr_nxt  = wr_cnt + TW'(wr_step);
  assign cfg_ok  = (cfg_width != '0) && (cfg_height != '0);
  assign req     = !cmd_abort &&
                   (((state == ST_IDLE) && cmd_start) ||
                    ((state == ST_DONE) && cfg_continuous));
  assign load    = req && cfg_ok;
  assign bad     = req && !cfg_ok;

  // Count the in-flight read so the core's late request never overshoots.
  assign core_empty = !((state == ST_RUN) && !src_empty &&
                        ((rd_cnt + TW'(core_rdreq)) < total));

  assign busy       = active;
  assign frame_done = state == ST_DONE;
  assign cfg_err    = err_q;
  assign frame_cnt  = fcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      total  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_reg  <= '0;
      h_reg  <= '0;
      fcnt   <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= bad;
      if (rd_step) rd_cnt <= rd_nxt;
      if (wr_step) wr_cnt <= wr_nxt;
      if (load) begin
        total  <= TW'(cfg_width) * TW'(cfg_height);
        w_reg  <= cfg_width;
        h_reg  <= cfg_height;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
      if (cmd_abort && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE:  if (load) state <= ST_RUN;
          ST_RUN:   if (rd_nxt == total) state <= ST_DRAIN;
          ST_DRAIN: begin
            if (wr_nxt == total) begin
              state <= ST_DONE;
              fcnt  <= fcnt + FCNT_W'(1);
            end
          end
          ST_DONE:  state <= load ? ST_RUN : ST_IDLE;
        endcase
      end
    end
  end

  vip_xy_counter #(.WW(WW), .HW(HW)) u_xy (
    .clock  (clock),
    .reset  (reset),
    .clear  (load),
    .step   (wr_step),
    .width  (w_reg),
    .height (h_reg),
    .sof    (out_sof),
    .eol    (out_eol),
    .eof    (out_eof)
  );
endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Directed bench for vip_frame_ctrl with a one-cycle-latency core model.
// Each scenario task checks its own expectations inline.
module tb_vip_frame_ctrl;
  localparam int WW = 12;
  localparam int HW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [WW-1:0] cfg_width = '0;
  logic [HW-1:0] cfg_height = '0;
  logic          cfg_continuous = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic          src_empty = 1'b0;
  logic          core_empty;
  logic          core_rdreq;
  logic          core_wrreq;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic [15:0]   frame_cnt;
  logic          core_on = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  vip_frame_ctrl #(.WW(WW), .HW(HW)) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_continuous (cfg_continuous),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .src_empty      (src_empty),
    .core_empty     (core_empty),
    .core_rdreq     (core_rdreq),
    .core_wrreq     (core_wrreq),
    .busy           (busy),
    .frame_done     (frame_done),
    .cfg_err        (cfg_err),
    .out_sof        (out_sof),
    .out_eol        (out_eol),
    .out_eof        (out_eof),
    .frame_cnt      (frame_cnt)
  );

  // Core: registered read request, write one cycle after each read.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      core_rdreq <= 1'b0;
      core_wrreq <= 1'b0;
    end else begin
      core_rdreq <= core_on & ~core_empty;
      core_wrreq <= core_rdreq;
    end
  end

  int n_rd = 0, n_wr = 0, n_done = 0, n_err = 0;
  int n_viol = 0, n_idle = 0, cyc = 0, wr_cyc = 0;
  int gap = 0, fidx = 0;
  logic [31:0] sof_l = '0, eol_l = '0, eof_l = '0;
  logic [31:0] last_sof = '0, last_eol = '0, last_eof = '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (core_rdreq) n_rd <= n_rd + 1;
      if (cfg_err) n_err <= n_err + 1;
      if (src_empty && !core_empty) n_viol <= n_viol + 1;
      if (core_wrreq && busy) begin
        n_wr   <= n_wr + 1;
        fidx   <= fidx + 1;
        wr_cyc <= cyc;
        sof_l  <= sof_l | (32'(out_sof) << (fidx + 1));
        eol_l  <= eol_l | (32'(out_eol) << (fidx + 1));
        eof_l  <= eof_l | (32'(out_eof) << (fidx + 1));
      end
      if (frame_done) begin
        n_done   <= n_done + 1;
        gap      <= cyc - wr_cyc;
        last_sof <= sof_l;
        last_eol <= eol_l;
        last_eof <= eof_l;
      end
      if (frame_done || !busy) begin
        fidx  <= 0;
        sof_l <= '0;
        eol_l <= '0;
        eof_l <= '0;
      end
      if (!busy && !frame_done) n_idle <= n_idle + 1;
    end
  end

  task automatic start(input int w, input int h);
    @(negedge clock);
    cfg_width  = WW'(w);
    cfg_height = HW'(h);
    cmd_start  = 1'b1;
    @(negedge clock);
    cmd_start  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tests++; if (core_empty !== 1'b1) begin fails++; $display("FAIL rst_core_empty got=%b exp=1", core_empty); end
    tests++; if (frame_done !== 1'b0 || cfg_err !== 1'b0) begin fails++; $display("FAIL rst_pulses got=%b%b exp=00", frame_done, cfg_err); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt); end
    tests++; if ({out_sof, out_eol, out_eof} !== 3'b000) begin fails++; $display("FAIL rst_tags got=%b exp=000", {out_sof, out_eol, out_eof}); end
    reset = 1'b0;
    core_on = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    int r0, w0, d0;
    bit ok;
    r0 = n_rd; w0 = n_wr; d0 = n_done;
    start(4, 2);
    wait_done(d0 + 1, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout got=%0d exp=1", n_done - d0); end
    repeat (5) @(negedge clock);
    tests++; if (n_rd - r0 !== 8) begin fails++; $display("FAIL basic_reads got=%0d exp=8", n_rd - r0); end
    tests++; if (n_wr - w0 !== 8) begin fails++; $display("FAIL basic_writes got=%0d exp=8", n_wr - w0); end
    tests++; if (last_eol !== 32'h110) begin fails++; $display("FAIL basic_eol got=%h exp=110", last_eol); end
    tests++; if (last_eof !== 32'h100) begin fails++; $display("FAIL basic_eof got=%h exp=100", last_eof); end
    tests++; if (last_sof !== 32'h002) begin fails++; $display("FAIL basic_sof got=%h exp=002", last_sof); end
    tests++; if (gap !== 1) begin fails++; $display("FAIL basic_done_gap got=%0d exp=1", gap); end
    tests++; if (n_done - d0 !== 1) begin fails++; $display("FAIL basic_done_cnt got=%0d exp=1", n_done - d0); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_src_toggle;
    int r0, w0, d0, v0;
    bit ok;
    r0 = n_rd; w0 = n_wr; d0 = n_done; v0 = n_viol;
    start(4, 2);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (i % 3 == 2) src_empty = ~src_empty;
      if (n_done >= d0 + 1) begin
        ok = 1'b1;
        break;
      end
    end
    src_empty = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL src_timeout got=%0d exp=1", n_done - d0); end
    repeat (5) @(negedge clock);
    tests++; if (n_viol - v0 !== 0) begin fails++; $display("FAIL src_gate got=%0d exp=0", n_viol - v0); end
    tests++; if (n_rd - r0 !== 8) begin fails++; $display("FAIL src_reads got=%0d exp=8", n_rd - r0); end
    tests++; if (n_wr - w0 !== 8) begin fails++; $display("FAIL src_writes got=%0d exp=8", n_wr - w0); end
    tests++; if (n_done - d0 !== 1) begin fails++; $display("FAIL src_done got=%0d exp=1", n_done - d0); end
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL src_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_abort;
    int r0, d0;
    bit ok;
    r0 = n_rd; d0 = n_done;
    start(4, 2);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (n_rd - r0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    tests++; if (!ok) begin fails++; $display("FAIL abort_timeout got=%0d exp=3", n_rd - r0); end
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", busy); end
    tests++; if (core_empty !== 1'b1) begin fails++; $display("FAIL abort_empty got=%b exp=1", core_empty); end
    repeat (20) @(negedge clock);
    tests++; if (n_done - d0 !== 0) begin fails++; $display("FAIL abort_done got=%0d exp=0", n_done - d0); end
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL abort_frame_cnt got=%0d exp=2", frame_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_stay_idle got=%b exp=0", busy); end
  endtask

  task automatic test_cfg_err;
    int r0, w0, d0, e0;
    bit ok;
    e0 = n_err;
    @(negedge clock);
    cfg_width = '0;
    cfg_height = HW'(2);
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_busy got=%b exp=0", busy); end
    @(negedge clock);
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL err_one_cycle got=%b exp=0", cfg_err); end
    r0 = n_rd; w0 = n_wr; d0 = n_done;
    start(4, 2);
    repeat (3) @(negedge clock);
    cfg_width = WW'(1);
    cfg_height = HW'(1);
    cmd_start = 1'b1;
    @(negedge clock);
    cmd_start = 1'b0;
    wait_done(d0 + 1, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL busy_start_timeout got=%0d exp=1", n_done - d0); end
    repeat (5) @(negedge clock);
    tests++; if (n_rd - r0 !== 8) begin fails++; $display("FAIL busy_start_reads got=%0d exp=8", n_rd - r0); end
    tests++; if (n_wr - w0 !== 8) begin fails++; $display("FAIL busy_start_writes got=%0d exp=8", n_wr - w0); end
    tests++; if (last_eol !== 32'h110) begin fails++; $display("FAIL busy_start_eol got=%h exp=110", last_eol); end
    tests++; if (n_err - e0 !== 1) begin fails++; $display("FAIL err_count got=%0d exp=1", n_err - e0); end
    tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL busy_start_frame_cnt got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_continuous;
    int r0, d0, i0;
    bit ok;
    r0 = n_rd; d0 = n_done;
    cfg_continuous = 1'b1;
    start(2, 2);
    i0 = n_idle;
    wait_done(d0 + 2, 200, ok);
    cfg_continuous = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL cont_timeout2 got=%0d exp=2", n_done - d0); end
    wait_done(d0 + 3, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL cont_timeout3 got=%0d exp=3", n_done - d0); end
    tests++; if (n_idle - i0 !== 0) begin fails++; $display("FAIL cont_idle_gap got=%0d exp=0", n_idle - i0); end
    repeat (6) @(negedge clock);
    tests++; if (n_rd - r0 !== 12) begin fails++; $display("FAIL cont_reads got=%0d exp=12", n_rd - r0); end
    tests++; if (n_done - d0 !== 3) begin fails++; $display("FAIL cont_done got=%0d exp=3", n_done - d0); end
    tests++; if (frame_cnt !== 16'd6) begin fails++; $display("FAIL cont_frame_cnt got=%0d exp=6", frame_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_stop got=%b exp=0", busy); end
  endtask

  task automatic test_1x1;
    int r0, d0;
    bit ok;
    r0 = n_rd; d0 = n_done;
    start(1, 1);
    wait_done(d0 + 1, 100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL one_timeout got=%0d exp=1", n_done - d0); end
    repeat (4) @(negedge clock);
    tests++; if (n_rd - r0 !== 1) begin fails++; $display("FAIL one_reads got=%0d exp=1", n_rd - r0); end
    tests++; if ({last_sof, last_eol, last_eof} !== {32'h2, 32'h2, 32'h2}) begin fails++; $display("FAIL one_tags got=%h/%h/%h exp=2/2/2", last_sof, last_eol, last_eof); end
    tests++; if (gap !== 1) begin fails++; $display("FAIL one_gap got=%0d exp=1", gap); end
    tests++; if (frame_cnt !== 16'd7) begin fails++; $display("FAIL one_frame_cnt got=%0d exp=7", frame_cnt); end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    start(4, 2);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || core_empty !== 1'b1) begin fails++; $display("FAIL midrst_state got=%b%b exp=01", busy, core_empty); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL midrst_frame_cnt got=%0d exp=0", frame_cnt); end
    d0 = n_done; e0 = n_err;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    tests++; if (n_done - d0 !== 0 || n_err - e0 !== 0) begin fails++; $display("FAIL midrst_pulse got=%0d/%0d exp=0/0", n_done - d0, n_err - e0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_src_toggle();
    test_abort();
    test_cfg_err();
    test_continuous();
    test_1x1();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vip_frame_ctrl.md
VIP_FRAME_CTRL -- requirements
Module: vip_frame_ctrl

Interface
REQ-001 Parameter WW, default 12, bit width of cfg_width and of the x counter.
REQ-002 Parameter HW, default 12, bit width of cfg_height and of the y counter.
REQ-003 Port clock  input  1  rising-edge clock; reset reset, asynchronous, active-high; clock clock.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port cfg_width  input  WW  pixels per line; sampled on accepted start.
REQ-006 Port cfg_height  input  HW  lines per frame; sampled on accepted start.
REQ-007 Port cfg_continuous  input  1  1 = auto-restart the next frame after done.
REQ-008 Port cmd_start  input  1  single-cycle frame start request.
REQ-009 Port cmd_abort  input  1  single-cycle abort request.
REQ-010 Port src_empty  input  1  empty flag of the upstream pixel FIFO.
REQ-011 Port core_empty  output  1  gated empty flag presented to the processing core's FIFO-read empty input.
REQ-012 Port core_rdreq  input  1  the core's registered read request (monitor only).
REQ-013 Port core_wrreq  input  1  the core's write strobe to the downstream FIFO (monitor only).
REQ-014 Port busy  output  1  high in RUN or DRAIN.
REQ-015 Port frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 Port cfg_err  output  1  one-cycle pulse on start rejected for zero dimension.
REQ-017 Port out_sof / out_eol / out_eof  output  1 each  position tags, valid only while core_wrreq=1.
REQ-018 Port frame_cnt  output  16  completed frames since reset; wraps at 65535 to 0.

Function
REQ-019 States: IDLE, RUN, DRAIN, DONE; encoding is a shared package constant.
REQ-020 IDLE->RUN on cmd_start with cfg_width!=0 and cfg_height!=0; registers total=cfg_width*cfg_height (WW+HW bits), clears rd_cnt, wr_cnt, x, y.
REQ-021 cmd_start with either dimension zero in IDLE: cfg_err pulses the next cycle; state stays IDLE.
REQ-022 cmd_start outside IDLE is ignored (no error).
REQ-023 core_empty = 1 unless state==RUN, src_empty==0 and (rd_cnt + core_rdreq) < total (combinational), so that the core's one-cycle-late read request never exceeds total.
REQ-024 rd_cnt increments by 1 on every cycle with core_rdreq=1 in RUN or DRAIN.
REQ-025 RUN->DRAIN in the cycle rd_cnt reaches total.
REQ-026 wr_cnt increments on every cycle with core_wrreq=1 in RUN or DRAIN; x/y raster counters advance with it: x wraps at cfg_width-1 to 0 and y increments; y clears when the frame completes.
REQ-027 out_sof = core_wrreq & x==0 & y==0; out_eol = core_wrreq & x==cfg_width-1; out_eof = out_eol & y==cfg_height-1.
REQ-028 DRAIN->DONE in the cycle wr_cnt reaches total; frame_done is high for exactly the one DONE cycle; frame_cnt increments in the same cycle.
REQ-029 DONE->RUN if cfg_continuous=1 (re-sample cfg, recompute total, clear counters); if the re-sampled dimension is zero, go to IDLE with cfg_err; else DONE->IDLE.
REQ-030 cmd_abort in RUN, DRAIN or DONE: next state IDLE, core_empty=1 from the following cycle, no frame_done, no frame_cnt increment; cmd_abort wins over simultaneous cmd_start; core writes after abort are not counted.
REQ-031 A 1x1 frame is legal: exactly one core_rdreq, sof, eol and eof on the single write.

Reset
REQ-032 On reset: state IDLE, rd_cnt, wr_cnt, x, y, total, frame_cnt = 0, frame_done = cfg_err = 0; busy = 0, core_empty = 1, out_* = 0.
REQ-033 Reset asserted mid-frame takes effect immediately; no pulse is produced on release.

Structure
REQ-034 Shared package vip_pkg holds the state encoding, WW/HW defaults and frame_cnt width.
REQ-035 One sub-module vip_xy_counter (raster x/y counter with sof/eol/eof tags) is instantiated for the write side.

Verification
REQ-036 4x2, src never empty -> exactly 8 core_rdreq, eol on writes 4 and 8, eof on write 8, frame_done one cycle after write 8, frame_cnt=1.
REQ-037 4x2, src_empty toggling every 3 cycles -> core_empty high whenever src_empty high, still exactly 8 reads, 8 writes, one frame_done.
REQ-038 cmd_abort after 3 reads -> IDLE next cycle, busy=0, core_empty=1, frame_done never pulses, frame_cnt unchanged.
REQ-039 cfg_continuous=1, 2x2, 3 frames -> 12 reads, frame_done pulses 3 times, frame_cnt=3, no IDLE cycle between frames.
REQ-040 cmd_start with cfg_width=0 -> cfg_err one pulse, busy stays 0; cmd_start while busy -> ignored, counts unaffected.
REQ-041 1x1 frame -> single read, sof=eol=eof=1 on the only write, frame_done follows.
